// File: rtl/key_flag_gen.sv
// key_flag_gen: turns two active-low board buttons into debounced
// one-cycle press flags (flag1/flag2) for the LED chaser.
// Each key has a 2-FF synchroniser, a 4-state debounce FSM and a counter.
// Optional feature macro: KEY_REPEAT_EN adds auto-repeat pulses while held.
module key_flag_gen #(
  parameter int DEB_CNT = 1_000_000,
  parameter int REP_DLY = 25_000_000,
  parameter int REP_PER = 5_000_000,
  parameter int CW      = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key1_n,
  input  logic key2_n,
  output logic flag1,
  output logic flag2,
  output logic key1_down,
  output logic key2_down
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_FILT = 2'd1,
    DOWN   = 2'd2,
    R_FILT = 2'd3
  } state_e;

  localparam logic [CW-1:0] DebLast = CW'(DEB_CNT - 1);
  localparam logic [CW-1:0] RepDlyLast = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] RepPerLast = CW'(REP_PER - 1);
  localparam longint CntLimit = longint'(1) << CW;

  // Parameter sanity: the counter must hold every compare value, and a
  // repeat period below 2 would make flags high on consecutive cycles.
  if (DEB_CNT < 1 || REP_DLY < 1 || REP_PER < 2 ||
      longint'(DEB_CNT) > CntLimit || longint'(REP_DLY) > CntLimit ||
      longint'(REP_PER) > CntLimit || RepDlyLast > RepDlyLast + RepPerLast) begin : gBadCfg
    $error("key_flag_gen: counter parameters out of range");
  end

  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    keyS;
  state_e        state_q [2];
  state_e        state_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    pulse;
  logic          flag1_q, flag2_q;
`ifdef KEY_REPEAT_EN
  logic [1:0]    rep_q, rep_d;
`endif

  // Two-flop synchronisers for both raw keys; released (1) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {key2_n, key1_n};
      sync2_q <= sync1_q;
    end
  end

  assign keyS = sync2_q;

  // Debounce FSM next-state, counter and press-pulse decode for each key.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse[i]   = 1'b0;
`ifdef KEY_REPEAT_EN
      rep_d[i]   = rep_q[i];
`endif
      unique case (state_q[i])
        IDLE: begin
          if (!keyS[i]) begin
            state_d[i] = P_FILT;
            cnt_d[i]   = '0;
          end
        end
        P_FILT: begin
          if (keyS[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= DebLast) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
            pulse[i]   = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
        DOWN: begin
          if (keyS[i]) begin
            state_d[i] = R_FILT;
            cnt_d[i]   = '0;
`ifdef KEY_REPEAT_EN
            rep_d[i]   = 1'b0;
`endif
          end else begin
`ifdef KEY_REPEAT_EN
            if ((!rep_q[i] && cnt_q[i] >= RepDlyLast) ||
                (rep_q[i] && cnt_q[i] >= RepPerLast)) begin
              cnt_d[i] = '0;
              rep_d[i] = 1'b1;
              pulse[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
`else
            cnt_d[i] = '0;
`endif
          end
        end
        R_FILT: begin
          if (!keyS[i]) begin
            state_d[i] = DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= DebLast) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State, counter and repeat-phase registers for both keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
`ifdef KEY_REPEAT_EN
      rep_q <= 2'b00;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
`ifdef KEY_REPEAT_EN
      rep_q <= rep_d;
`endif
    end
  end

  // Registered flags; key1 wins a coincident pulse and key2's is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag1_q <= 1'b0;
      flag2_q <= 1'b0;
    end else begin
      flag1_q <= pulse[0];
      flag2_q <= pulse[1] & ~pulse[0];
    end
  end

  assign flag1     = flag1_q;
  assign flag2     = flag2_q;
  assign key1_down = (state_q[0] == DOWN) || (state_q[0] == R_FILT);
  assign key2_down = (state_q[1] == DOWN) || (state_q[1] == R_FILT);

endmodule

// File: tb/tb_key_flag_gen.sv
// Directed bench for key_flag_gen with DEB_CNT=4, REP_DLY=10, REP_PER=3.
// Inputs change 1 ns after a rising edge; "edge k" is the k-th rising edge
// after the stimulus change, and outputs are sampled 1 ns after that edge.
// A press applied before edge 0 gives its flag just after edge 6.
module tb_key_flag_gen;

  localparam int DebCnt = 4;
  localparam int RepDly = 10;
  localparam int RepPer = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key1_n = 1'b1;
  logic key2_n = 1'b1;
  logic flag1, flag2, key1_down, key2_down;

  int checkCount = 0;
  int passCount = 0;
  int flagTotal;

  key_flag_gen #(
    .DEB_CNT(DebCnt),
    .REP_DLY(RepDly),
    .REP_PER(RepPer),
    .CW(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key1_n(key1_n),
    .key2_n(key2_n),
    .flag1(flag1),
    .flag2(flag2),
    .key1_down(key1_down),
    .key2_down(key2_down)
  );

  always #5 clk = ~clk;

  // Compare one observed bit against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", tag, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic k1, input logic k2);
    key1_n = k1;
    key2_n = k2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected flag1 at edge k while key1 is held from edge 0 onwards.
  function automatic logic heldFlag(input int k);
`ifdef KEY_REPEAT_EN
    return (k == DebCnt + 2) ||
           (k >= DebCnt + 2 + RepDly && ((k - (DebCnt + 2 + RepDly)) % RepPer) == 0);
`else
    return (k == DebCnt + 2);
`endif
  endfunction

  initial begin
    logic [19:0] bouncePat;
    bouncePat = 20'b1111_1111_1111_0011_0011;

    $display("[TB] key_flag_gen bench start");
    applyStimulus(1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("rst flag1", flag1, 1'b0);
    checkOutput("rst flag2", flag2, 1'b0);
    checkOutput("rst key1_down", key1_down, 1'b0);
    checkOutput("rst key2_down", key2_down, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("idle flag1", flag1, 1'b0);
    checkOutput("idle key1_down", key1_down, 1'b0);

    // Long hold of key1: single flag at edge 6 (plus repeats when enabled).
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 38; k++) begin
      tick();
      checkOutput($sformatf("hold flag1 k=%0d", k), flag1, heldFlag(k));
      checkOutput($sformatf("hold key1_down k=%0d", k), key1_down, k >= 6);
      checkOutput($sformatf("hold flag2 k=%0d", k), flag2, 1'b0);
    end
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("release flag1 k=%0d", k), flag1, 1'b0);
      checkOutput($sformatf("release key1_down k=%0d", k), key1_down, k < 6);
    end

    // Short glitch on key2 never reaches DOWN.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k == 3) applyStimulus(1'b1, 1'b1);
      tick();
      checkOutput($sformatf("glitch flag2 k=%0d", k), flag2, 1'b0);
      checkOutput($sformatf("glitch key2_down k=%0d", k), key2_down, 1'b0);
    end

    // Steady press then a bouncy release: one flag, down falls at edge 14.
    applyStimulus(1'b0, 1'b1);
    flagTotal = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (flag1) flagTotal++;
    end
    checkOutput("bounce press one flag", flagTotal == 1, 1'b1);
    checkOutput("bounce press key1_down", key1_down, 1'b1);
    for (int t = 0; t < 20; t++) begin
      applyStimulus(bouncePat[t], 1'b1);
      tick();
      checkOutput($sformatf("bounce flag1 t=%0d", t), flag1, 1'b0);
      checkOutput($sformatf("bounce key1_down t=%0d", t), key1_down, t < 14);
    end

    // Both keys fall together: key1 wins, key2 pulse dropped.
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      tick();
      checkOutput($sformatf("both flag1 k=%0d", k), flag1, k == 6);
      checkOutput($sformatf("both flag2 k=%0d", k), flag2, 1'b0);
    end
    checkOutput("both key1_down", key1_down, 1'b1);
    checkOutput("both key2_down", key2_down, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("both released key1_down", key1_down, 1'b0);
    checkOutput("both released key2_down", key2_down, 1'b0);

    // Key2 alone produces its own flag.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("key2 flag2 k=%0d", k), flag2, k == 6);
      checkOutput($sformatf("key2 flag1 k=%0d", k), flag1, 1'b0);
      checkOutput($sformatf("key2 key2_down k=%0d", k), key2_down, k >= 6);
    end
    applyStimulus(1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("key2 released key2_down", key2_down, 1'b0);

    // Reset in the middle of key1's press filter, key kept held throughout.
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("prerst flag1 k=%0d", k), flag1, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst flag1", flag1, 1'b0);
    checkOutput("midrst key1_down", key1_down, 1'b0);
    repeat (2) tick();
    checkOutput("inrst flag1", flag1, 1'b0);
    checkOutput("inrst key1_down", key1_down, 1'b0);
    checkOutput("inrst flag2", flag2, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checkOutput($sformatf("postrst flag1 k=%0d", k), flag1, k == 6);
      checkOutput($sformatf("postrst key1_down k=%0d", k), key1_down, k >= 6);
    end
    applyStimulus(1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("postrst released key1_down", key1_down, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
